thresh_fifo: RTL and testbench
==============================

THRESH_FIFO -- requirements
Module: thresh_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 6, meaning entry capacity (>=2; non-power-of-two legal).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, meaning almost_full threshold (1..FIFO_DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning almost_empty threshold (0..FIFO_DEPTH-1).
REQ-005 SHALL have derived localparam CW = $clog2(FIFO_DEPTH+1), meaning count width.
REQ-006 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port clear  input  1  synchronous flush, same effect as reset.
REQ-009 SHALL have ports in_data  input  DATA_WIDTH, in_valid  input  1, in_ready  output  1  (write channel).
REQ-010 SHALL have ports out_data  output  DATA_WIDTH, out_valid  output  1, out_ready  input  1  (read channel).
REQ-011 SHALL have port count  output  CW  current occupancy.
REQ-012 SHALL have ports almost_full  output  1 and almost_empty  output  1  threshold flags.
REQ-013 SHALL have ports overflow  output  1 and drop_cnt  output  8  rejected-write status (present only under REQ-027).

Function
REQ-014 SHALL drive in_ready = (count < FIFO_DEPTH) and out_valid = (count > 0), combinationally from registered count.
REQ-015 SHALL accept a write when in_valid & in_ready, storing in_data at waddr; SHALL complete a read when out_valid & out_ready.
REQ-016 SHALL present out_data = mem[raddr] combinationally; first-word fall-through, a word written at edge N visible with out_valid at cycle N+1.
REQ-017 SHALL advance waddr/raddr by 1 per accepted write/read, wrapping FIFO_DEPTH-1 -> 0 (explicit compare, not bit overflow).
REQ-018 SHALL update count +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-019 SHALL, when full, refuse writes even if a read occurs the same cycle (no pass-through); when empty, SHALL not bypass in_data to out_data.
REQ-020 SHALL drive almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), combinational from count.
REQ-021 SHALL keep out_data undefined-but-stable content irrelevant when out_valid=0; bench shall not check it.

Reset
REQ-022 SHALL, when rstn=0 or clear=1 at a rising edge, set waddr=0, raddr=0, count=0; clear overrides any same-cycle write/read.
REQ-023 SHALL produce after reset: in_ready=1, out_valid=0, count=0, almost_full=0 (AF_LEVEL>=1), almost_empty=1, overflow=0, drop_cnt=0.
REQ-024 SHALL not reset storage memory; stale contents never become visible because count=0.

Configuration
REQ-025 SHALL compile overflow/drop_cnt logic only when macro THRESH_FIFO_ERR_EN is defined.
REQ-026 SHALL, with THRESH_FIFO_ERR_EN, set overflow (sticky) and increment drop_cnt (saturating at 255) on every cycle with in_valid=1 and in_ready=0; both cleared by reset or clear.
REQ-027 SHALL, without THRESH_FIFO_ERR_EN, omit ports overflow and drop_cnt entirely; all other behaviour identical.

Structure
REQ-028 SHALL place default parameter constants and a wrap-increment function ptr_next(ptr, depth) in package thresh_fifo_pkg.
REQ-029 SHALL instantiate sub-module fifo_ptr (wrapping pointer with enable, sync reset/clear) twice, for waddr and raddr.
REQ-030 SHALL keep storage as a flat register array of FIFO_DEPTH x DATA_WIDTH.

Verification (DATA_WIDTH=8, FIFO_DEPTH=6, AF_LEVEL=5, AE_LEVEL=1)
REQ-031 SHALL cover: write 0x11..0x16 with out_ready=0 -> count 1..6, almost_full at count 5, in_ready=0 at 6; then read -> 0x11..0x16 in order, almost_empty at count<=1.
REQ-032 SHALL cover: 20 writes/reads interleaved across wrap, pointers passing 5->0 -> output sequence equals input sequence, no loss.
REQ-033 SHALL cover: full FIFO, in_valid=1 and out_ready=1 same cycle -> one read, write refused, count 6->5; with ERR_EN overflow=1, drop_cnt=1.
REQ-034 SHALL cover: count=3, simultaneous write and read for 4 cycles -> count stays 3, data in order.
REQ-035 SHALL cover: clear=1 with in_valid=1, out_ready=1, count=4 -> next cycle count=0, out_valid=0, in_ready=1, overflow=0, drop_cnt=0.
REQ-036 SHALL cover: in_valid=1 held 300 cycles while full with ERR_EN -> drop_cnt saturates at 255, overflow stays 1.

Source files
------------

// File: rtl/thresh_fifo_pkg.sv
// Shared defaults and pointer helper for thresh_fifo.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package thresh_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 6;
  localparam int DEF_AE_LEVEL   = 1;

  // Increment with an explicit wrap at depth-1, so non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/thresh_fifo_ptr.sv
// fifo_ptr: wrapping address pointer 0..DEPTH-1 with advance enable.
// Latency: pointer moves on the rising edge after en is seen high.
// Backpressure: none; the caller qualifies en with its handshake.
module fifo_ptr
  import thresh_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;

  assign w_next = PW'(ptr_next(32'(r_ptr), DEPTH));
  assign ptr    = r_ptr;

  // Pointer register; reset and clear both return it to entry 0.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/thresh_fifo.sv
// thresh_fifo: first-word fall-through FIFO with almost_full/almost_empty flags.
// Latency: a word written at edge N is visible on out_data with out_valid at N+1.
// Backpressure: in_ready drops at full (no pass-through); THRESH_FIFO_ERR_EN adds overflow/drop_cnt.
module thresh_fifo
  import thresh_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef THRESH_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         w_waddr;
  logic [PW-1:0]         w_raddr;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_wr;
  logic                  w_rd;

  // Handshakes come only from the registered count, so a full FIFO refuses
  // a write even when a read frees a slot in the same cycle.
  assign w_in_ready  = (r_count < DEPTH_C);
  assign w_out_valid = (r_count != '0);
  assign w_wr        = in_valid & w_in_ready;
  assign w_rd        = w_out_valid & out_ready;

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign out_data     = r_mem[w_raddr];

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wptr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .en    (w_wr),
    .ptr   (w_waddr)
  );

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rptr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .en    (w_rd),
    .ptr   (w_raddr)
  );

  // Storage is not reset; stale words stay hidden because count is zero.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_waddr] <= in_data;
    end
  end

  // Occupancy: +1 write only, -1 read only, hold on both or neither.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef THRESH_FIFO_ERR_EN
  logic       r_overflow;
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = in_valid & ~w_in_ready;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  // Sticky overflow flag and saturating count of refused write cycles.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thresh_fifo.sv
module tb_thresh_fifo;

  logic       clk;
  logic       rstn;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
`ifdef THRESH_FIFO_ERR_EN
  logic       overflow;
  logic [7:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  thresh_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (6),
    .AF_LEVEL   (5),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef THRESH_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write n words base, base+1, ... with reads held off.
  task automatic fill(input int n, input logic [7:0] base);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick(); tick();
    rstn = 1'b1;
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0)        begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
`ifdef THRESH_FIFO_ERR_EN
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
`endif
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h11 + 8'(i);
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 5)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i + 1 >= 5)); end
      checks++; if (in_ready !== (i + 1 < 6)) begin errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, (i + 1 < 6)); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL fill_fwft i=%0d got=%b/%h exp=1/11", i, out_valid, out_data); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'h11 + 8'(i)); end
      tick();
      checks++; if (count !== 3'(5 - i)) begin errors++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 5 - i); end
      checks++; if (almost_empty !== (5 - i <= 1)) begin errors++; $display("FAIL drain_ae i=%0d got=%b exp=%b", i, almost_empty, (5 - i <= 1)); end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_empty got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int mc = 0;
    int sent = 0;
    int recv = 0;
    bit wr, rd;
    for (int c = 0; c < 60 && recv < 20; c++) begin
      in_valid  = (sent < 20) && (c % 3 != 2);
      out_ready = (c % 4 != 1);
      in_data   = 8'h40 + 8'(sent);
      wr = in_valid && (mc < 6);
      rd = out_ready && (mc > 0);
      checks++; if (in_ready !== (mc < 6)) begin errors++; $display("FAIL wrap_in_ready c=%0d got=%b exp=%b", c, in_ready, (mc < 6)); end
      if (rd) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, out_data, q[0]); end
        void'(q.pop_front());
        recv++;
        mc--;
      end
      if (wr) begin
        q.push_back(in_data);
        sent++;
        mc++;
      end
      tick();
      checks++; if (count !== 3'(mc)) begin errors++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count, mc); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (recv != 20) begin errors++; $display("FAIL wrap_total got=%0d exp=20", recv); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_rw();
    do_clear();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL frw_clear got=%0d exp=0", count); end
    fill(6, 8'hA0);
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL frw_head got=%h exp=a0", out_data); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd5) begin errors++; $display("FAIL frw_count got=%0d exp=5", count); end
`ifdef THRESH_FIFO_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL frw_overflow got=%b exp=1", overflow); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL frw_drop got=%0d exp=1", drop_cnt); end
`endif
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL frw_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'hA1 + 8'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL frw_end got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    fill(3, 8'h31);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h34 + 8'(i);
      checks++; if (out_data !== 8'h31 + 8'(i)) begin errors++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, out_data, 8'h31 + 8'(i)); end
      tick();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_count i=%0d got=%0d exp=3", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data !== 8'h35 + 8'(i)) begin errors++; $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, out_data, 8'h35 + 8'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end got=%0d exp=0", count); end
  endtask

  task automatic test_clear();
    fill(6, 8'h60);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL clr_pre got=%0d exp=4", count); end
    clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h99;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0)        begin errors++; $display("FAIL clr_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL clr_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL clr_ae got=%b exp=1", almost_empty); end
`ifdef THRESH_FIFO_ERR_EN
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
    checks++; if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL clr_drop got=%0d exp=0", drop_cnt); end
`endif
    fill(1, 8'h77);
    checks++; if (out_data !== 8'h77 || count !== 3'd1) begin errors++; $display("FAIL clr_reuse got=%h/%0d exp=77/1", out_data, count); end
    do_clear();
  endtask

`ifdef THRESH_FIFO_ERR_EN
  task automatic test_saturate();
    fill(6, 8'h80);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) begin
        checks++; if (drop_cnt !== 8'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", drop_cnt); end
      end
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL sat_overflow got=%b exp=1", overflow); end
    checks++; if (count !== 3'd6)      begin errors++; $display("FAIL sat_count got=%0d exp=6", count); end
    do_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_back_to_back();
    test_clear();
`ifdef THRESH_FIFO_ERR_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
